rr_mux_arbiter: RTL and testbench
=================================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of every data port.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a_valid  input  1  requester A offers a word.
REQ-005 a_data  input  DATA_WIDTH  requester A word.
REQ-006 a_ready  output  1  A word accepted this cycle.
REQ-007 b_valid  input  1  requester B offers a word.
REQ-008 b_data  input  DATA_WIDTH  requester B word.
REQ-009 b_ready  output  1  B word accepted this cycle.
REQ-010 out_valid  output  1  out_data holds a word.
REQ-011 out_data  output  DATA_WIDTH  granted word, registered.
REQ-012 out_sel  output  1  source of out_data: 0 = A, 1 = B; mux select.
REQ-013 out_ready  input  1  consumer takes the word this cycle.

Function
REQ-014 Transfer on any port SHALL occur when valid and ready are both 1 at a rising edge.
REQ-015 Block SHALL hold a one-word output register; states IDLE (out_valid=0) and FULL (out_valid=1).
REQ-016 Slot SHALL be open when state is IDLE, or FULL with out_ready=1.
REQ-017 a_ready/b_ready SHALL be combinational from state, out_ready, a_valid, b_valid and last_grant only; never from data.
REQ-018 Slot closed: a_ready=0 and b_ready=0.
REQ-019 Slot open, only one requester valid: that requester's ready=1, the other's ready=0.
REQ-020 Slot open, both valid: the requester not equal to last_grant SHALL get ready=1; the other ready=0.
REQ-021 Slot open, neither valid: both ready=0.
REQ-022 At most one of a_ready, b_ready SHALL be 1 in any cycle.
REQ-023 On accept: out_data <= winner data, out_sel <= winner id, last_grant <= winner id, state -> FULL, in the same edge; latency input-to-output 1 cycle.
REQ-024 FULL with out_ready=1 and no accept: state -> IDLE, out_valid=0; out_data and out_sel hold their last values.
REQ-025 FULL with out_ready=1 and an accept: state stays FULL, new word replaces old with no bubble (full throughput, one word per cycle).
REQ-026 FULL with out_ready=0: out_data, out_sel, last_grant SHALL hold; both ready=0.
REQ-027 last_grant SHALL change only on an accept.
REQ-028 Requester held valid SHALL be granted within 2 accepts (no starvation); with both continuously valid and out_ready=1, grants alternate A,B,A,B...
REQ-029 Valid deasserted by a requester before acceptance SHALL not corrupt state; no word is stored unless ready was 1.

Reset
REQ-030 rst=1 at an edge: state -> IDLE, out_valid=0, out_data=0, out_sel=0, last_grant=B (so A wins first tie).
REQ-031 While rst=1: a_ready=0, b_ready=0, no accept regardless of inputs.
REQ-032 Reset while FULL SHALL discard the held word; first edge after rst falls may accept.

Verification
REQ-033 Reset then a_valid=1,a_data=8'h3C,b_valid=0,out_ready=1 -> a_ready=1 same cycle; next cycle out_valid=1,out_data=8'h3C,out_sel=0.
REQ-034 Both valid continuously, a_data=8'hA5,b_data=8'h5A, out_ready=1 from reset -> out_data sequence A5,5A,A5,5A; out_sel 0,1,0,1; never both ready.
REQ-035 FULL with out_data=8'h11, out_ready=0 for 4 cycles, both valid -> out_data stays 8'h11, a_ready=b_ready=0 all 4 cycles; on out_ready=1 next grant goes per REQ-020.
REQ-036 Single word B=8'hFF, then no valid, out_ready=1 -> one cycle out_valid=1,out_sel=1, then out_valid=0 with out_data held at 8'hFF.
REQ-037 rst pulsed while FULL (out_data=8'h77) -> next cycle out_valid=0,out_data=0,out_sel=0; subsequent tie grants A first.
REQ-038 Randomized a/b/out_ready with scoreboard per requester -> every accepted word appears on out exactly once, in order per source, with matching out_sel.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin arbiter feeding a one-word registered output slot.
// Latency: an accepted word appears on out_data one cycle after its accept edge.
// Backpressure: the slot accepts a new word when it is empty or is being drained
//    this cycle (out_ready=1), so back-to-back words flow with no bubble.
// Ports:
//    clk, rst             clock, synchronous active-high reset
//    a_valid/a_data/a_ready   requester A handshake (id 0)
//    b_valid/b_data/b_ready   requester B handshake (id 1)
//    out_valid/out_data/out_sel/out_ready   output slot, out_sel = source id
module rr_mux_arbiter #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_valid,
   input  logic [DATA_WIDTH-1:0] a_data,
   output logic                  a_ready,
   input  logic                  b_valid,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic                  b_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_sel,
   input  logic                  out_ready
);

   typedef enum logic {
      IDLE = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t state;
   logic   last_grant;   // 0 = A won last, 1 = B won last
   logic   slot_open;
   logic   a_win;
   logic   b_win;
   logic   accept;

   // The slot can take a word if it is empty or its current word leaves now.
   assign slot_open = (state == IDLE) || out_ready;

   // On a tie the requester that did not win last time goes first.
   assign a_win = a_valid && (!b_valid ||  last_grant);
   assign b_win = b_valid && (!a_valid || !last_grant);

   // Ready depends only on handshake state, never on data; held low in reset.
   assign a_ready = !rst && slot_open && a_win;
   assign b_ready = !rst && slot_open && b_win;
   assign accept  = a_ready || b_ready;

   assign out_valid = (state == FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         out_data   <= '0;
         out_sel    <= 1'b0;
         last_grant <= 1'b1;   // pretend B won last so A takes the first tie
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= FULL;
                  out_data   <= a_ready ? a_data : b_data;
                  out_sel    <= b_ready;
                  last_grant <= b_ready;
               end
            end
            FULL: begin
               if (accept) begin
                  // Old word drains and new one lands on the same edge.
                  out_data   <= a_ready ? a_data : b_data;
                  out_sel    <= b_ready;
                  last_grant <= b_ready;
               end else if (out_ready) begin
                  // Data and select hold their last values while idle.
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_valid, b_valid, out_ready;
   logic [7:0] a_data, b_data;
   logic       a_ready, b_ready, out_valid, out_sel;
   logic [7:0] out_data;

   always #5 clk = ~clk;

   rr_mux_arbiter #(.DATA_WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .a_valid  (a_valid),
      .a_data   (a_data),
      .a_ready  (a_ready),
      .b_valid  (b_valid),
      .b_data   (b_data),
      .b_ready  (b_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_sel  (out_sel),
      .out_ready(out_ready)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: contents of the output slot plus who won last.
   bit         m_full;
   logic [7:0] m_data;
   bit         m_sel;
   bit         m_last;   // 1 = B won last, so A wins the next tie
   // Words accepted but not yet delivered, per source.
   logic [7:0] qa[$];
   logic [7:0] qb[$];

   // Values observed during the most recent step (before its edge).
   logic       obs_ar, obs_br, obs_ov, obs_os;
   logic [7:0] obs_od;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_full = 1'b0;
      m_data = 8'h00;
      m_sel  = 1'b0;
      m_last = 1'b1;
      qa.delete();
      qb.delete();
   endtask

   // One clock cycle: drive, check against the model mid-cycle, then advance.
   task automatic step(input logic r, input logic av, input logic [7:0] ad,
                       input logic bv, input logic [7:0] bd, input logic ordy);
      bit open, ea, eb;
      int depth;
      @(negedge clk);
      rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
      #1;
      obs_ar = a_ready; obs_br = b_ready; obs_ov = out_valid;
      obs_os = out_sel; obs_od = out_data;

      open = !m_full || ordy;
      ea = 1'b0;
      eb = 1'b0;
      if (!r && open) begin
         if (av && bv) begin
            ea = m_last;
            eb = !m_last;
         end else begin
            ea = av;
            eb = bv;
         end
      end
      chk("a_ready", obs_ar, ea);
      chk("b_ready", obs_br, eb);
      chk("ready_onehot", obs_ar & obs_br, 0);
      chk("out_valid", obs_ov, m_full);
      chk("out_data", obs_od, m_data);
      chk("out_sel", obs_os, m_sel);

      // Scoreboard: a delivered word must be the oldest pending from its source.
      if (!r && m_full && ordy) begin
         depth = (obs_os === 1'b1) ? qb.size() : qa.size();
         chk("sb_depth", depth, 1);
         if (depth > 0) begin
            if (obs_os === 1'b1) chk("sb_word_b", obs_od, qb.pop_front());
            else                 chk("sb_word_a", obs_od, qa.pop_front());
         end
      end

      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         if (ea) qa.push_back(ad);
         if (eb) qb.push_back(bd);
         if (ea || eb) begin
            m_full = 1'b1;
            m_data = ea ? ad : bd;
            m_sel  = eb;
            m_last = eb;
         end else if (m_full && ordy) begin
            m_full = 1'b0;
         end
      end
   endtask

   initial begin
      logic [7:0] seq_exp[4];
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
      a_data = 8'h00; b_data = 8'h00;
      repeat (2) @(posedge clk);
      model_reset();

      // Reset state, then a single A word.
      step(1, 0, 8'h00, 0, 8'h00, 1);
      chk("rst_out_valid", obs_ov, 0);
      chk("rst_out_data", obs_od, 8'h00);
      step(0, 1, 8'h3C, 0, 8'h00, 1);
      chk("a_only_ready", obs_ar, 1);
      step(0, 0, 8'h00, 0, 8'h00, 1);
      chk("a_only_valid", obs_ov, 1);
      chk("a_only_data", obs_od, 8'h3C);
      chk("a_only_sel", obs_os, 0);

      // Both valid from reset: strict alternation starting with A.
      step(1, 0, 8'h00, 0, 8'h00, 1);
      seq_exp[0] = 8'hA5; seq_exp[1] = 8'h5A; seq_exp[2] = 8'hA5; seq_exp[3] = 8'h5A;
      step(0, 1, 8'hA5, 1, 8'h5A, 1);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 8'hA5, 1, 8'h5A, 1);
         chk("alt_data", obs_od, seq_exp[i]);
         chk("alt_sel", obs_os, i % 2);
      end

      // Stalled slot holds its word and refuses both requesters.
      step(1, 0, 8'h00, 0, 8'h00, 0);
      step(0, 1, 8'h11, 0, 8'h00, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 8'h33, 1, 8'h22, 0);
         chk("stall_data", obs_od, 8'h11);
         chk("stall_ready", {obs_ar, obs_br}, 2'b00);
      end
      step(0, 1, 8'h33, 1, 8'h22, 1);
      chk("stall_release_b", obs_br, 1);

      // Single B word drains; data stays put afterwards.
      step(1, 0, 8'h00, 0, 8'h00, 1);
      step(0, 0, 8'h00, 1, 8'hFF, 1);
      step(0, 0, 8'h00, 0, 8'h00, 1);
      chk("b_only_valid", obs_ov, 1);
      chk("b_only_sel", obs_os, 1);
      step(0, 0, 8'h00, 0, 8'h00, 1);
      chk("b_drained_valid", obs_ov, 0);
      chk("b_drained_data", obs_od, 8'hFF);

      // Reset while full discards the word; A wins the next tie.
      step(1, 0, 8'h00, 0, 8'h00, 0);
      step(0, 1, 8'h77, 0, 8'h00, 0);
      step(1, 1, 8'h12, 1, 8'h34, 1);
      chk("rst_full_no_ready", {obs_ar, obs_br}, 2'b00);
      chk("rst_full_held", obs_od, 8'h77);
      step(0, 1, 8'h12, 1, 8'h34, 1);
      chk("post_rst_valid", obs_ov, 0);
      chk("post_rst_data", obs_od, 8'h00);
      chk("post_rst_sel", obs_os, 0);
      chk("post_rst_a_first", obs_ar, 1);

      // Randomized traffic against the model and scoreboard.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 249) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
              1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));
      end

      // Drain and confirm nothing accepted was lost.
      repeat (3) step(0, 0, 8'h00, 0, 8'h00, 1);
      chk("drain_a", qa.size(), 0);
      chk("drain_b", qb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
